// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, mul/div occupancy, dmem handshake.
// Optional HAZARD_PERF_CNT_EN adds saturating per-cause stall cycle counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        id_uses_rt_i,
    input  logic        id_branch_taken_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_mem_r_i,
    input  logic        ex_w_reg_ena_i,
    input  logic        ex_md_start_i,
    input  logic        mem_access_i,
    input  logic        dmem_ack_i,
    output logic        stall_pc_o,
    output logic        stall_if_id_o,
    output logic        clear_if_id_o,
    output logic        stall_id_ex_o,
    output logic        clear_id_ex_o,
    output logic        stall_ex_mem_o,
    output logic        clear_ex_mem_o,
    output logic        clear_mem_wb_o,
    output logic        dmem_req_o,
    output logic        dmem_timeout_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_mem_stall_o,
    output logic [31:0] perf_md_stall_o,
    output logic [31:0] perf_lu_stall_o
`endif
);

    localparam int unsigned WW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned MDW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [WW-1:0]  WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [MDW-1:0] MD_LOAD   = MDW'(MD_LATENCY - 1);

    typedef enum logic {MIdle, MWait} mem_state_e;
    typedef enum logic {MdIdle, MdBusy} md_state_e;

    mem_state_e     mem_state_q, mem_state_d;
    md_state_e      md_state_q, md_state_d;
    logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [MDW-1:0] md_cnt_q, md_cnt_d;

    logic mem_stall;
    logic md_stall;
    logic lu;
    logic timeout;

    // Memory handshake FSM
    always_comb begin
        mem_state_d = mem_state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_stall   = 1'b0;
        timeout     = 1'b0;
        case (mem_state_q)
            MIdle: begin
                if (mem_access_i) begin
                    mem_stall   = 1'b1;
                    mem_state_d = MWait;
                    wait_cnt_d  = '0;
                end
            end
            MWait: begin
                if (dmem_ack_i) begin
                    mem_state_d = MIdle;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout     = 1'b1;
                    mem_state_d = MIdle;
                end else begin
                    mem_stall  = 1'b1;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: mem_state_d = MIdle;
        endcase
    end

    // Mul/div occupancy FSM; release waits for any memory stall to clear
    always_comb begin
        md_state_d = md_state_q;
        md_cnt_d   = md_cnt_q;
        md_stall   = 1'b0;
        case (md_state_q)
            MdIdle: begin
                if (ex_md_start_i) begin
                    md_stall   = 1'b1;
                    md_cnt_d   = MD_LOAD;
                    md_state_d = MdBusy;
                end
            end
            MdBusy: begin
                if (md_cnt_q != '0) begin
                    md_stall = 1'b1;
                    md_cnt_d = md_cnt_q - 1'b1;
                end else if (mem_stall) begin
                    md_stall = 1'b1;
                end else begin
                    md_state_d = MdIdle;
                end
            end
            default: md_state_d = MdIdle;
        endcase
    end

    assign lu = ex_mem_r_i & ex_w_reg_ena_i & (ex_rd_i != 5'd0) &
                ((ex_rd_i == id_rs_i) | (id_uses_rt_i & (ex_rd_i == id_rt_i)));

    always_comb begin
        stall_pc_o     = 1'b0;
        stall_if_id_o  = 1'b0;
        clear_if_id_o  = 1'b0;
        stall_id_ex_o  = 1'b0;
        clear_id_ex_o  = 1'b0;
        stall_ex_mem_o = 1'b0;
        clear_ex_mem_o = 1'b0;
        clear_mem_wb_o = 1'b0;
        dmem_req_o     = 1'b0;
        dmem_timeout_o = 1'b0;
        if (rst) begin
            dmem_req_o     = (mem_state_q == MWait);
            dmem_timeout_o = timeout;
            clear_mem_wb_o = timeout;
            if (mem_stall) begin
                stall_pc_o     = 1'b1;
                stall_if_id_o  = 1'b1;
                stall_id_ex_o  = 1'b1;
                stall_ex_mem_o = 1'b1;
                clear_mem_wb_o = 1'b1;
            end else if (md_stall) begin
                stall_pc_o     = 1'b1;
                stall_if_id_o  = 1'b1;
                stall_id_ex_o  = 1'b1;
                clear_ex_mem_o = 1'b1;
            end else if (lu) begin
                stall_pc_o    = 1'b1;
                stall_if_id_o = 1'b1;
                clear_id_ex_o = 1'b1;
            end else if (id_branch_taken_i) begin
                clear_if_id_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_state_q <= MIdle;
            md_state_q  <= MdIdle;
            wait_cnt_q  <= '0;
            md_cnt_q    <= '0;
        end else begin
            mem_state_q <= mem_state_d;
            md_state_q  <= md_state_d;
            wait_cnt_q  <= wait_cnt_d;
            md_cnt_q    <= md_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_mem_q, perf_md_q, perf_lu_q;
    logic        cause_md, cause_lu;

    assign cause_md = md_stall & ~mem_stall;
    assign cause_lu = lu & ~md_stall & ~mem_stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_mem_q <= '0;
            perf_md_q  <= '0;
            perf_lu_q  <= '0;
        end else begin
            if (mem_stall && perf_mem_q != 32'hFFFF_FFFF) perf_mem_q <= perf_mem_q + 32'd1;
            if (cause_md && perf_md_q != 32'hFFFF_FFFF)   perf_md_q  <= perf_md_q + 32'd1;
            if (cause_lu && perf_lu_q != 32'hFFFF_FFFF)   perf_lu_q  <= perf_lu_q + 32'd1;
        end
    end

    assign perf_mem_stall_o = rst ? perf_mem_q : 32'd0;
    assign perf_md_stall_o  = rst ? perf_md_q  : 32'd0;
    assign perf_lu_stall_o  = rst ? perf_lu_q  : 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with default MD_LATENCY=4, TIMEOUT=16.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, id_branch_taken, ex_mem_r, ex_w_reg_ena, ex_md_start;
    logic       mem_access, dmem_ack;
    logic       stall_pc, stall_if_id, clear_if_id, stall_id_ex, clear_id_ex;
    logic       stall_ex_mem, clear_ex_mem, clear_mem_wb, dmem_req, dmem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_mem, perf_md, perf_lu;
`endif

    int compared = 0;
    int mismatched = 0;

    // {stall_pc, stall_if_id, clear_if_id, stall_id_ex, clear_id_ex,
    //  stall_ex_mem, clear_ex_mem, clear_mem_wb, dmem_req, dmem_timeout}
    localparam logic [9:0] O_NONE = 10'b00_0_00_00_0_00;
    localparam logic [9:0] O_LU   = 10'b11_0_01_00_0_00;
    localparam logic [9:0] O_BR   = 10'b00_1_00_00_0_00;
    localparam logic [9:0] O_MD   = 10'b11_0_10_01_0_00;
    localparam logic [9:0] O_MEMS = 10'b11_0_10_10_1_00;
    localparam logic [9:0] O_MEMW = 10'b11_0_10_10_1_10;
    localparam logic [9:0] O_REQ  = 10'b00_0_00_00_0_10;
    localparam logic [9:0] O_TOUT = 10'b00_0_00_00_1_11;

    pipe_hazard_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .id_rs_i           (id_rs),
        .id_rt_i           (id_rt),
        .id_uses_rt_i      (id_uses_rt),
        .id_branch_taken_i (id_branch_taken),
        .ex_rd_i           (ex_rd),
        .ex_mem_r_i        (ex_mem_r),
        .ex_w_reg_ena_i    (ex_w_reg_ena),
        .ex_md_start_i     (ex_md_start),
        .mem_access_i      (mem_access),
        .dmem_ack_i        (dmem_ack),
        .stall_pc_o        (stall_pc),
        .stall_if_id_o     (stall_if_id),
        .clear_if_id_o     (clear_if_id),
        .stall_id_ex_o     (stall_id_ex),
        .clear_id_ex_o     (clear_id_ex),
        .stall_ex_mem_o    (stall_ex_mem),
        .clear_ex_mem_o    (clear_ex_mem),
        .clear_mem_wb_o    (clear_mem_wb),
        .dmem_req_o        (dmem_req),
        .dmem_timeout_o    (dmem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_mem_stall_o  (perf_mem),
        .perf_md_stall_o   (perf_md),
        .perf_lu_stall_o   (perf_lu)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, required $finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // Inputs set before the call apply to this cycle; outputs sampled on the negedge.
    task automatic chk(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        @(negedge clk);
        obs = {stall_pc, stall_if_id, clear_if_id, stall_id_ex, clear_id_ex,
               stall_ex_mem, clear_ex_mem, clear_mem_wb, dmem_req, dmem_timeout};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rt = 1'b0; id_branch_taken = 1'b0;
        ex_mem_r = 1'b0; ex_w_reg_ena = 1'b0; ex_md_start = 1'b0;
        mem_access = 1'b1; dmem_ack = 1'b0;
        chk("reset_gated", O_NONE);
        mem_access = 1'b0;
        chk("reset_hold", O_NONE);
        rst = 1'b1;
        chk("idle", O_NONE);

        // Load-use via rs, rd==0 suppression, via rt
        ex_mem_r = 1'b1; ex_w_reg_ena = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        chk("lu_rs", O_LU);
        ex_rd = 5'd0; id_rs = 5'd0;
        chk("lu_rd0", O_NONE);
        ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
        chk("lu_rt", O_LU);
        id_uses_rt = 1'b0;
        chk("lu_rt_unused", O_NONE);
        id_uses_rt = 1'b1; id_branch_taken = 1'b1;
        chk("br_under_lu", O_LU);
        ex_mem_r = 1'b0;
        chk("br_alone", O_BR);
        id_branch_taken = 1'b0; ex_w_reg_ena = 1'b0; ex_rd = 5'd0; id_rt = 5'd0;
        id_uses_rt = 1'b0;
        chk("br_done", O_NONE);

        // Memory access, ack on the fourth WAIT cycle
        mem_access = 1'b1;
        chk("m_idle", O_MEMS);
        for (int i = 0; i < 3; i++) chk("m_wait", O_MEMW);
        dmem_ack = 1'b1;
        chk("m_ack", O_REQ);
        mem_access = 1'b0; dmem_ack = 1'b0;
        chk("m_after_ack", O_NONE);

        // Timeout: 1 IDLE + 15 WAIT stall cycles, then abort pulse
        mem_access = 1'b1;
        chk("t_idle", O_MEMS);
        for (int i = 0; i < 15; i++) chk("t_wait", O_MEMW);
        chk("t_timeout", O_TOUT);
        mem_access = 1'b0;
        chk("t_after", O_NONE);

        // Ack coincident with timeout: ack wins
        mem_access = 1'b1;
        chk("at_idle", O_MEMS);
        for (int i = 0; i < 15; i++) chk("at_wait", O_MEMW);
        dmem_ack = 1'b1;
        chk("at_ack_wins", O_REQ);
        mem_access = 1'b0; dmem_ack = 1'b0;
        chk("at_after", O_NONE);

        // Mul/div alone: exactly 4 hold cycles
        ex_md_start = 1'b1;
        for (int i = 0; i < 4; i++) chk("md_busy", O_MD);
        chk("md_release", O_NONE);
        ex_md_start = 1'b0;
        chk("md_after", O_NONE);

        // Mul/div with a 5-cycle memory stall from its third cycle
        ex_md_start = 1'b1;
        chk("mdm_c0", O_MD);
        chk("mdm_c1", O_MD);
        mem_access = 1'b1;
        chk("mdm_c2_mem", O_MEMS);
        for (int i = 0; i < 4; i++) chk("mdm_mem_wait", O_MEMW);
        dmem_ack = 1'b1;
        chk("mdm_release", O_REQ);
        ex_md_start = 1'b0; mem_access = 1'b0; dmem_ack = 1'b0;
        chk("mdm_after", O_NONE);

        // Reset mid-WAIT
        mem_access = 1'b1;
        chk("r_idle", O_MEMS);
        chk("r_wait", O_MEMW);
        rst = 1'b0;
        chk("r_reset", O_NONE);
        rst = 1'b1; mem_access = 1'b0;
        chk("r_after", O_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
